// File: rtl/led_blink_multi.sv
// led_blink_multi
// Multi-channel LED driver. Each channel runs one of four modes:
// OFF, ON, BLINK with a programmable half-period, or DIM with a PWM duty.
// A channel is configured through a single-cycle write strobe. A global
// sync input restarts every BLINK channel in phase.
//
// Ports
//   i_clk       system clock (25 MHz)
//   i_rst       asynchronous, active-high reset
//   i_wr_en     config write strobe, one cycle
//   i_wr_ch     target channel index
//   i_wr_mode   0=OFF, 1=ON, 2=BLINK, 3=DIM
//   i_wr_half   BLINK half-period minus one, in cycles
//   i_wr_duty   DIM duty (LED on while shared PWM counter < duty)
//   i_sync      restart all BLINK channels in phase
//   o_wr_ack    one-cycle pulse: write accepted
//   o_wr_err    one-cycle pulse: write rejected (channel out of range)
//   o_led       registered LED drive, bit n = channel n, active-high
module led_blink_multi #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned DEFAULT_HALF = 12_499_999,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [1:0]        i_wr_mode,
  input  logic [CNT_W-1:0]  i_wr_half,
  input  logic [PWM_W-1:0]  i_wr_duty,
  input  logic              i_sync,
  output logic              o_wr_ack,
  output logic              o_wr_err,
  output logic [NUM_CH-1:0] o_led
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_DIM   = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PWM_W-1:0] PWM_ONE  = PWM_W'(1);

  // Decoded channel hit. An out-of-range index matches no channel, which
  // is exactly the rejection condition, so no magnitude compare is needed.
  logic [NUM_CH-1:0] ch_hit;
  logic              wr_ok;
  logic              wr_bad;

  logic [PWM_W-1:0]  pwm_q, pwm_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  assign wr_ok  = i_wr_en & (|ch_hit);
  assign wr_bad = i_wr_en & ~(|ch_hit);

  // Shared free-running PWM counter and write response pulses.
  always_comb begin
    pwm_d = pwm_q + PWM_ONE;
    ack_d = wr_ok;
    err_d = wr_bad;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pwm_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign o_wr_ack = ack_q;
  assign o_wr_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             blink_q, blink_d;
    logic             led_q,  led_d;

    assign ch_hit[g] = (i_wr_ch == CH_W'(g));

    always_comb begin
      mode_d  = mode_q;
      half_d  = half_q;
      duty_d  = duty_q;
      cnt_d   = cnt_q;
      blink_d = blink_q;
      led_d   = 1'b0;

      // A write restarts the channel the same way sync does, so on a
      // same-edge write+sync the write simply takes priority here.
      if (wr_ok && ch_hit[g]) begin
        mode_d  = mode_t'(i_wr_mode);
        half_d  = i_wr_half;
        duty_d  = i_wr_duty;
        cnt_d   = '0;
        blink_d = 1'b1;
      end else if (mode_q == MODE_BLINK) begin
        if (i_sync) begin
          cnt_d   = '0;
          blink_d = 1'b1;
        end else if (cnt_q == half_q) begin
          cnt_d   = '0;
          blink_d = ~blink_q;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end else begin
        cnt_d = '0;
      end

      // LED function from the current (already registered) configuration.
      case (mode_q)
        MODE_OFF:   led_d = 1'b0;
        MODE_ON:    led_d = 1'b1;
        MODE_BLINK: led_d = blink_q;
        MODE_DIM:   led_d = (pwm_q < duty_q);
        default:    led_d = 1'b0;
      endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        mode_q  <= MODE_OFF;
        half_q  <= HALF_RST;
        duty_q  <= '0;
        cnt_q   <= '0;
        blink_q <= 1'b0;
        led_q   <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        half_q  <= half_d;
        duty_q  <= duty_d;
        cnt_q   <= cnt_d;
        blink_q <= blink_d;
        led_q   <= led_d;
      end
    end

    assign o_led[g] = led_q;
  end

endmodule

// File: tb/tb_led_blink_multi.sv
module tb_led_blink_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] ch;
  logic [1:0] mode;
  logic [3:0] half;
  logic [2:0] duty;
  logic       sync;
  logic       ack;
  logic       err;
  logic [2:0] led;

  int total = 0;
  int bad   = 0;

  // Free-running reference for the shared PWM phase.
  logic [2:0] tb_pwm;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) tb_pwm <= 3'd0;
    else     tb_pwm <= tb_pwm + 3'd1;
  end

  led_blink_multi #(
    .NUM_CH      (3),
    .CNT_W       (4),
    .PWM_W       (3),
    .DEFAULT_HALF(9)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wr_en  (en),
    .i_wr_ch  (ch),
    .i_wr_mode(mode),
    .i_wr_half(half),
    .i_wr_duty(duty),
    .i_sync   (sync),
    .o_wr_ack (ack),
    .o_wr_err (err),
    .o_led    (led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one write; returns just after the sampling edge, where the
  // response pulse is checked.
  task automatic do_write(input logic [1:0] c, input logic [1:0] m,
                          input logic [3:0] h, input logic [2:0] d,
                          input logic ok);
    en = 1'b1; ch = c; mode = m; half = h; duty = d;
    tick();
    en = 1'b0;
    total++;
    if (ack !== ok || err !== !ok) begin
      bad++;
      $display("FAIL write_resp ch=%0d: ack=%b err=%b, required ack=%b err=%b",
               c, ack, err, ok, !ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ch = '0; mode = '0; half = '0; duty = '0; sync = 1'b0;
    repeat (3) tick();
    total++;
    if (led !== 3'b000 || ack !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: led=%b ack=%b err=%b, required 000 0 0", led, ack, err);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (led !== 3'b000 || ack !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: led=%b ack=%b err=%b, required 000 0 0",
                 i, led, ack, err);
      end
    end
  endtask

  task automatic test_on();
    do_write(2'd1, 2'd1, 4'd0, 3'd0, 1'b1);
    total++;
    if (led !== 3'b000) begin
      bad++;
      $display("FAIL on_latency: led=%b, required 000", led);
    end
    tick();
    total++;
    if (led !== 3'b010 || ack !== 1'b0) begin
      bad++;
      $display("FAIL on_led: led=%b ack=%b, required 010 0", led, ack);
    end
  endtask

  task automatic test_blink();
    logic [2:0] exp;
    do_write(2'd0, 2'd2, 4'd3, 3'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      exp = {2'b01, ((i / 4) % 2 == 0)};
      total++;
      if (led !== exp) begin
        bad++;
        $display("FAIL blink_half3 cyc=%0d: led=%b, required %b", i, led, exp);
      end
    end
    do_write(2'd0, 2'd2, 4'd0, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {2'b01, (i % 2 == 0)};
      total++;
      if (led !== exp) begin
        bad++;
        $display("FAIL blink_half0 cyc=%0d: led=%b, required %b", i, led, exp);
      end
    end
  endtask

  task automatic test_dim();
    int         ones;
    logic [2:0] prev;
    logic       e;
    ones = 0;
    do_write(2'd2, 2'd3, 4'd0, 3'd3, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      prev = tb_pwm - 3'd1;
      e = (prev < 3'd3);
      if (led[2] === 1'b1) ones++;
      total++;
      if (led[2] !== e) begin
        bad++;
        $display("FAIL dim3 cyc=%0d: led2=%b, required %b", i, led[2], e);
      end
    end
    total++;
    if (ones != 6) begin
      bad++;
      $display("FAIL dim3_count: high=%0d of 16, required 6", ones);
    end
    do_write(2'd2, 2'd3, 4'd0, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (led[2] !== 1'b0) begin
        bad++;
        $display("FAIL dim0 cyc=%0d: led2=%b, required 0", i, led[2]);
      end
    end
  endtask

  task automatic test_sync();
    logic       e;
    logic [2:0] exp;
    do_write(2'd0, 2'd2, 4'd5, 3'd0, 1'b1);
    tick();
    do_write(2'd1, 2'd2, 4'd5, 3'd0, 1'b1);
    tick();
    tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      e = ((i / 6) % 2 == 0);
      exp = {1'b0, e, e};
      total++;
      if (led !== exp) begin
        bad++;
        $display("FAIL sync cyc=%0d: led=%b, required %b", i, led, exp);
      end
    end
  endtask

  task automatic test_back_to_back_err();
    do_write(2'd0, 2'd0, 4'd0, 3'd0, 1'b1);
    do_write(2'd1, 2'd1, 4'd0, 3'd0, 1'b1);
    do_write(2'd2, 2'd0, 4'd0, 3'd0, 1'b1);
    tick();
    total++;
    if (led !== 3'b010) begin
      bad++;
      $display("FAIL b2b_led: led=%b, required 010", led);
    end
    do_write(2'd3, 2'd1, 4'd0, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (led !== 3'b010 || ack !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL err_after cyc=%0d: led=%b ack=%b err=%b, required 010 0 0",
                 i, led, ack, err);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_write(2'd0, 2'd2, 4'd3, 3'd0, 1'b1);
    tick();
    tick();
    total++;
    if (led !== 3'b011) begin
      bad++;
      $display("FAIL pre_reset: led=%b, required 011", led);
    end
    rst = 1'b1; en = 1'b1; ch = 2'd2; mode = 2'd1;
    #1;
    total++;
    if (led !== 3'b000 || ack !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: led=%b ack=%b, required 000 0", led, ack);
    end
    tick();
    total++;
    if (led !== 3'b000 || ack !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_drop: led=%b ack=%b err=%b, required 000 0 0", led, ack, err);
    end
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (led !== 3'b000 || ack !== 1'b0) begin
        bad++;
        $display("FAIL post_reset cyc=%0d: led=%b ack=%b, required 000 0", i, led, ack);
      end
    end
    do_write(2'd0, 2'd1, 4'd0, 3'd0, 1'b1);
    tick();
    total++;
    if (led !== 3'b001) begin
      bad++;
      $display("FAIL rewrite_ch0: led=%b, required 001", led);
    end
  endtask

  initial begin
    test_reset();
    test_on();
    test_blink();
    test_dim();
    test_sync();
    test_back_to_back_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
